// File: rtl/data_lane_striper_xn.sv
// data_lane_striper_xn: stripes a byte-serial symbol stream round-robin across
// 1..MAX_LANES active lanes. One output word carries one byte per active lane.
// A packet that ends mid-stripe has its remaining active lanes filled with PAD
// (K=1). Data passes through a staging register and then an output register,
// so the block sustains one byte per cycle at every link width, including x1.
module data_lane_striper_xn #(
  parameter int         MAX_LANES  = 8,
  parameter logic [7:0] PAD_SYMBOL = 8'hF7,
  parameter int         LW         = $clog2(MAX_LANES) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [LW-1:0]          link_width_i,
  input  logic [7:0]             data_i,
  input  logic                   data_k_i,
  input  logic                   data_valid_i,
  input  logic                   data_last_i,
  output logic                   data_ready_o,
  output logic [MAX_LANES*8-1:0] lane_data_o,
  output logic [MAX_LANES-1:0]   lane_k_o,
  output logic [MAX_LANES-1:0]   lane_en_o,
  output logic                   lane_valid_o,
  input  logic                   lane_ready_i,
  output logic                   busy_o
);

  localparam int PW = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1;

  logic [MAX_LANES-1:0][7:0] stage_data_q;
  logic [MAX_LANES-1:0]      stage_k_q;
  logic                      stage_full_q;
  logic [PW-1:0]             ptr_q;
  logic [LW-1:0]             width_q;
  logic                      ready_en_q;

  logic [MAX_LANES-1:0][7:0] out_data_q;
  logic [MAX_LANES-1:0]      out_k_q;
  logic [MAX_LANES-1:0]      out_en_q;
  logic                      out_valid_q;

  logic                      width_legal;
  logic [LW-1:0]             legal_width;
  logic [LW-1:0]             cur_width;
  logic [LW-1:0]             ptr_ext;
  logic                      move;
  logic                      xfer;
  logic                      stripe_end;
  logic                      complete;
  logic                      pad_stripe;
  logic [MAX_LANES-1:0]      width_mask;
  logic [MAX_LANES-1:0]      pad_mask;

  // An illegal width (zero, not a power of two, or too wide) falls back to x1.
  // The first byte of a stripe uses the incoming width; later bytes use the latch.
  always_comb begin
    width_legal = (link_width_i != '0)
               && ((link_width_i & (link_width_i - LW'(1))) == '0)
               && (link_width_i <= LW'(MAX_LANES));
    legal_width = width_legal ? link_width_i : LW'(1);
    cur_width   = (ptr_q == '0) ? legal_width : width_q;
    ptr_ext     = LW'(ptr_q);
    move        = stage_full_q && (!out_valid_q || lane_ready_i);
    data_ready_o = ready_en_q && (!stage_full_q || move);
    xfer        = data_valid_i && data_ready_o;
    stripe_end  = (ptr_ext == (cur_width - LW'(1)));
    complete    = xfer && (stripe_end || data_last_i);
    pad_stripe  = xfer && data_last_i && !stripe_end;
  end

  // Lane masks: active lanes of the staged stripe, and lanes to pad this cycle.
  always_comb begin
    width_mask = '0;
    pad_mask   = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (LW'(i) < width_q) width_mask[i] = 1'b1;
      if (pad_stripe && (LW'(i) > ptr_ext) && (LW'(i) < cur_width)) pad_mask[i] = 1'b1;
    end
  end

  // Staging register: collects bytes of the current stripe and tracks fill state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_data_q <= '0;
      stage_k_q    <= '0;
      stage_full_q <= 1'b0;
      ptr_q        <= '0;
      width_q      <= LW'(1);
      ready_en_q   <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (xfer) begin
        stage_data_q[ptr_q] <= data_i;
        stage_k_q[ptr_q]    <= data_k_i;
        if (ptr_q == '0) width_q <= legal_width;
      end
      for (int i = 0; i < MAX_LANES; i++) begin
        if (pad_mask[i]) begin
          stage_data_q[i] <= PAD_SYMBOL;
          stage_k_q[i]    <= 1'b1;
        end
      end
      if (complete) ptr_q <= '0;
      else if (xfer) ptr_q <= ptr_q + PW'(1);
      if (complete) stage_full_q <= 1'b1;
      else if (move) stage_full_q <= 1'b0;
    end
  end

  // Output register: takes a completed stripe and holds it until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_q  <= '0;
      out_k_q     <= '0;
      out_en_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (move) begin
      for (int i = 0; i < MAX_LANES; i++) begin
        out_data_q[i] <= width_mask[i] ? stage_data_q[i] : 8'h00;
      end
      out_k_q     <= stage_k_q & width_mask;
      out_en_q    <= width_mask;
      out_valid_q <= 1'b1;
    end else if (lane_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign lane_data_o  = out_data_q;
  assign lane_k_o     = out_k_q;
  assign lane_en_o    = out_en_q;
  assign lane_valid_o = out_valid_q;
  assign busy_o       = stage_full_q || out_valid_q || (ptr_q != '0);

endmodule

// File: tb/tb_data_lane_striper_xn.sv
// tb_data_lane_striper_xn: directed bench for data_lane_striper_xn (x8 build).
// Inputs change one time unit after a rising edge; outputs are sampled on the
// falling edge. Accepted output words are queued and compared to hand values.
module tb_data_lane_striper_xn;

  logic        clk_i;
  logic        rst_ni;
  logic [3:0]  link_width_i;
  logic [7:0]  data_i;
  logic        data_k_i;
  logic        data_valid_i;
  logic        data_last_i;
  logic        data_ready_o;
  logic [63:0] lane_data_o;
  logic [7:0]  lane_k_o;
  logic [7:0]  lane_en_o;
  logic        lane_valid_o;
  logic        lane_ready_i;
  logic        busy_o;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic [7:0]  en;
    int          hs;
  } word_t;

  word_t words[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    accepted = 0;

  data_lane_striper_xn #(.MAX_LANES(8), .PAD_SYMBOL(8'hF7)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .link_width_i (link_width_i),
    .data_i       (data_i),
    .data_k_i     (data_k_i),
    .data_valid_i (data_valid_i),
    .data_last_i  (data_last_i),
    .data_ready_o (data_ready_o),
    .lane_data_o  (lane_data_o),
    .lane_k_o     (lane_k_o),
    .lane_en_o    (lane_en_o),
    .lane_valid_o (lane_valid_o),
    .lane_ready_i (lane_ready_i),
    .busy_o       (busy_o)
  );

  // Free-running clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Edge counter: after rising edge N, cyc == N.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every output word that will be handshaked at the coming rising edge.
  always @(negedge clk_i) begin
    if (rst_ni && lane_valid_o && lane_ready_i)
      words.push_back('{lane_data_o, lane_k_o, lane_en_o, cyc + 1});
  end

  // Run-away guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Offer one byte and wait (bounded) until it is accepted; returns the accept edge.
  task automatic apply_stimulus(input logic [7:0] d, input logic k, input logic last, output int acc);
    data_i       = d;
    data_k_i     = k;
    data_last_i  = last;
    data_valid_i = 1'b1;
    acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (data_ready_o) begin
        acc = cyc + 1;
        accepted++;
        @(posedge clk_i);
        #1;
        break;
      end
    end
    if (acc < 0) check_output("accept_timeout", {127'b0, data_ready_o}, 128'd1);
  endtask

  task automatic idle_input();
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
    data_k_i     = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [63:0] d, input logic [7:0] k,
                             input logic [7:0] en, output int hs);
    word_t w;
    hs = -1;
    check_output({tag, "_present"}, {127'b0, (words.size() > 0)}, 128'd1);
    if (words.size() > 0) begin
      w  = words.pop_front();
      hs = w.hs;
      check_output(tag, {w.d, w.k, w.en}, {d, k, en});
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 100; n++) begin
      if (!busy_o) break;
      @(posedge clk_i);
      #1;
    end
    repeat (2) @(posedge clk_i);
    #1;
    check_output({tag, "_idle"}, {127'b0, busy_o}, 128'd0);
  endtask

  int acc [0:31];
  int hs;
  int base;
  logic [7:0] b;

  initial begin
    rst_ni       = 1'b0;
    link_width_i = 4'd4;
    data_i       = 8'h00;
    data_k_i     = 1'b0;
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
    lane_ready_i = 1'b1;

    // Reset state.
    #3;
    check_output("rst_data",  lane_data_o, 64'h0);
    check_output("rst_k",     lane_k_o, 8'h00);
    check_output("rst_en",    lane_en_o, 8'h00);
    check_output("rst_valid", lane_valid_o, 1'b0);
    check_output("rst_busy",  busy_o, 1'b0);
    check_output("rst_ready", data_ready_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_output("ready_after_reset", data_ready_o, 1'b1);

    // x4, two full stripes, no padding, latency of two edges to handshake.
    link_width_i = 4'd4;
    for (int i = 0; i < 8; i++) apply_stimulus(8'h10 + 8'(i), 1'b0, (i == 7), acc[i]);
    idle_input();
    wait_drain("x4_full");
    expect_word("x4_w0", 64'h00000000_13121110, 8'h00, 8'h0F, hs);
    check_output("x4_w0_lat", hs, acc[3] + 2);
    expect_word("x4_w1", 64'h00000000_17161514, 8'h00, 8'h0F, hs);
    check_output("x4_w1_lat", hs, acc[7] + 2);

    // x4, packet ends after two bytes of the second stripe: PAD on lanes 2,3.
    for (int i = 0; i < 6; i++) apply_stimulus(8'hA0 + 8'(i), 1'b0, (i == 5), acc[i]);
    idle_input();
    wait_drain("x4_pad");
    expect_word("pad_w0", 64'h00000000_A3A2A1A0, 8'h00, 8'h0F, hs);
    expect_word("pad_w1", 64'h00000000_F7F7A5A4, 8'h0C, 8'h0F, hs);

    // x1, 16 back-to-back bytes, one K byte; never stalls.
    link_width_i = 4'd1;
    for (int i = 0; i < 16; i++) apply_stimulus(8'h30 + 8'(i), (i == 5), (i == 15), acc[i]);
    idle_input();
    for (int i = 1; i < 16; i++) check_output("x1_no_stall", acc[i] - acc[i-1], 1);
    wait_drain("x1");
    check_output("x1_count", words.size(), 16);
    for (int i = 0; i < 16; i++) begin
      b = 8'h30 + 8'(i);
      expect_word("x1_w", {56'h0, b}, (i == 5) ? 8'h01 : 8'h00, 8'h01, hs);
    end

    // x8 under backpressure: 16 bytes fill output and staging, then stall.
    link_width_i = 4'd8;
    lane_ready_i = 1'b0;
    base = accepted;
    fork
      begin
        for (int i = 0; i < 24; i++) apply_stimulus(8'h40 + 8'(i), 1'b0, (i == 23), acc[i]);
        idle_input();
      end
      begin
        repeat (12) @(posedge clk_i);
        #1;
        check_output("bp_hold_early", lane_data_o, 64'h47464544_43424140);
        repeat (8) @(posedge clk_i);
        #1;
        check_output("bp_accepted", accepted - base, 16);
        check_output("bp_ready_low", data_ready_o, 1'b0);
        check_output("bp_valid", lane_valid_o, 1'b1);
        check_output("bp_hold_late", lane_data_o, 64'h47464544_43424140);
        check_output("bp_en", lane_en_o, 8'hFF);
        lane_ready_i = 1'b1;
      end
    join
    wait_drain("x8_bp");
    expect_word("bp_w0", 64'h47464544_43424140, 8'h00, 8'hFF, hs);
    expect_word("bp_w1", 64'h4F4E4D4C_4B4A4948, 8'h00, 8'hFF, hs);
    expect_word("bp_w2", 64'h57565554_53525150, 8'h00, 8'hFF, hs);

    // Width change mid-stripe takes effect only at the next stripe; 3 means x1.
    link_width_i = 4'd4;
    apply_stimulus(8'h60, 1'b0, 1'b0, acc[0]);
    check_output("mid_stripe_busy", busy_o, 1'b1);
    apply_stimulus(8'h61, 1'b0, 1'b0, acc[1]);
    link_width_i = 4'd2;
    apply_stimulus(8'h62, 1'b0, 1'b0, acc[2]);
    apply_stimulus(8'h63, 1'b0, 1'b0, acc[3]);
    apply_stimulus(8'h64, 1'b0, 1'b0, acc[4]);
    apply_stimulus(8'h65, 1'b0, 1'b1, acc[5]);
    link_width_i = 4'd3;
    apply_stimulus(8'h66, 1'b0, 1'b1, acc[6]);
    apply_stimulus(8'h67, 1'b0, 1'b0, acc[7]);
    idle_input();
    wait_drain("wchg");
    expect_word("wchg_x4", 64'h00000000_63626160, 8'h00, 8'h0F, hs);
    expect_word("wchg_x2", 64'h00000000_00006564, 8'h00, 8'h03, hs);
    expect_word("wchg_ill0", 64'h00000000_00000066, 8'h00, 8'h01, hs);
    expect_word("wchg_ill1", 64'h00000000_00000067, 8'h00, 8'h01, hs);

    // Reset with a word in the output register and another staged.
    link_width_i = 4'd4;
    lane_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus(8'h70 + 8'(i), 1'b0, (i == 7), acc[i]);
    idle_input();
    check_output("pre_rst_valid", lane_valid_o, 1'b1);
    check_output("pre_rst_ready", data_ready_o, 1'b0);
    check_output("pre_rst_data", lane_data_o, 64'h00000000_73727170);
    rst_ni = 1'b0;
    #1;
    check_output("async_rst_valid", lane_valid_o, 1'b0);
    check_output("async_rst_data", lane_data_o, 64'h0);
    check_output("async_rst_en", lane_en_o, 8'h00);
    check_output("async_rst_busy", busy_o, 1'b0);
    check_output("async_rst_ready", data_ready_o, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    lane_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_output("post_rst_ready", data_ready_o, 1'b1);
    repeat (10) @(posedge clk_i);
    #1;
    check_output("no_stale_word", words.size(), 0);
    check_output("no_stale_valid", lane_valid_o, 1'b0);

    // Recovery after reset: a short x2 packet.
    link_width_i = 4'd2;
    apply_stimulus(8'h80, 1'b0, 1'b0, acc[0]);
    apply_stimulus(8'h81, 1'b0, 1'b1, acc[1]);
    idle_input();
    wait_drain("recover");
    expect_word("recover_x2", 64'h00000000_00008180, 8'h00, 8'h03, hs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
